// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter that drives the
// select lines of the 4:1 mux.
//   NUM_REQ     : number of requesters (one per mux data input)
//   SEL_W       : width of the mux select / requester index
//   arb_state_t : arbiter state encoding
//   onehot()    : index -> one-hot grant vector
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req         : request vector
//   ptr         : index where the circular search starts
//   exclude_en  : when high, exclude_idx is never picked
//   exclude_idx : index to skip (the current owner on a hand-off)
//   pick        : first eligible requester found from ptr upwards, mod 4
//   any         : high when some eligible requester exists
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic               exclude_en,
    input  logic [SEL_W-1:0]   exclude_idx,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Index arithmetic is SEL_W wide, so the search wraps naturally.
            idx = ptr + SEL_W'(k);
            if (!any && req[idx] && !(exclude_en && (idx == exclude_idx))) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux between four requesters. Requester i
// owns mux input di; sel drives the mux select lines (sel[1]->s1, sel[0]->s0).
// An owner holding the grant for MAX_HOLD cycles while someone else waits is
// preempted (MAX_HOLD = 0 disables preemption).
//   clk      : system clock, all state changes on its rising edge
//   rst      : synchronous active-high reset
//   req      : request vector, req[i] held high while requester i wants di
//   grant    : registered one-hot grant, zero when idle
//   sel      : registered mux select, index of the granted requester
//   busy     : high while a grant is active
//   switch_p : one-cycle pulse when grant takes a new non-zero value
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       switch_p
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [SEL_W-1:0] pick_ptr;
    logic             pick_excl;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             at_limit;
    logic             handoff;

    // One picker serves both cases: from IDLE it searches from ptr; while
    // granted it searches from owner+1 with the owner excluded, so "any" is
    // also the "another request is pending" flag used for preemption.
    always_comb begin
        pick_ptr  = ptr;
        pick_excl = 1'b0;
        if (state == GRANT) begin
            pick_ptr  = sel + SEL_W'(1);
            pick_excl = 1'b1;
        end
    end

    rr_pick u_rr_pick (
        .req         (req),
        .ptr         (pick_ptr),
        .exclude_en  (pick_excl),
        .exclude_idx (sel),
        .pick        (pick),
        .any         (any)
    );

    always_comb begin
        at_limit = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
        handoff  = !req[sel] || (at_limit && any);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            switch_p <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            switch_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant    <= onehot(pick);
                        sel      <= pick;
                        busy     <= 1'b1;
                        switch_p <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (handoff) begin
                        ptr      <= sel + SEL_W'(1);
                        hold_cnt <= '0;
                        if (any) begin
                            grant    <= onehot(pick);
                            sel      <= pick;
                            switch_p <= 1'b1;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (at_limit) begin
                        hold_cnt <= '0;
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       switch_p;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .switch_p (switch_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic sw);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".switch_p"}, 32'(switch_p), 32'(sw));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;

        // Reset dominates a full request vector.
        tick();
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        tick();
        expect_out("idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        expect_out("idle1", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request, one-cycle latency, then release.
        req = 4'b0100;
        tick();
        expect_out("single.grant", 4'b0100, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("single.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        expect_out("single.release", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Round robin: each owner drops after 3 cycles; previous owner re-raises.
        do_reset();
        req = 4'b1111;
        tick();
        expect_out("rr.o0", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); tick();
        expect_out("rr.o0.hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110;
        tick();
        expect_out("rr.o1", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick(); tick();
        req = 4'b1101;
        tick();
        expect_out("rr.o2", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick(); tick();
        req = 4'b1011;
        tick();
        expect_out("rr.o3", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick(); tick();
        req = 4'b0111;
        tick();
        expect_out("rr.wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        tick();
        expect_out("rr.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Preemption: two permanent requesters alternate every 8 cycles.
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("pre.a", 4'b0001, 2'd0, 1'b1, (i == 0));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("pre.b", 4'b0010, 2'd1, 1'b1, (i == 0));
        end
        tick();
        expect_out("pre.c", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Lone requester is never preempted and never pulses switch_p.
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_out("lone", 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        // Owner drops while another requester arrives in the same cycle.
        do_reset();
        req = 4'b0100;
        tick();
        expect_out("simul.own", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        req = 4'b1000;
        tick();
        expect_out("simul.new", 4'b1000, 2'd3, 1'b1, 1'b1);

        // Reset mid-grant restores ptr to 0.
        do_reset();
        req = 4'b0010;
        tick();
        expect_out("midrst.own", 4'b0010, 2'd1, 1'b1, 1'b1);
        rst = 1'b1;
        req = 4'b1010;
        tick();
        expect_out("midrst.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("midrst.after", 4'b0010, 2'd1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
